axi_lite_slave_mem: RTL and testbench

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_slave_regfile.sv | 38 +++
 rtl/axi_lite_slave_mem.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared constants and FSM state encodings for the AXI4-Lite register-window slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic [1:0] resp_for(input logic hit);
    return hit ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_slave_regfile.sv
// Word storage for the register window: byte-enabled synchronous write port,
// combinational read port, cleared by the synchronous reset.
module axi_lite_slave_regfile #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // NOTE: the words are reset because software must read zeros after reset;
  // that makes this a flop array rather than an inferable RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave exposing C_NUM_REGS 32-bit words at C_BASEADDR; independent
// write (AW/W -> B) and read (AR -> R) FSMs, SLVERR outside the window.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'hC7000000,
  parameter int          C_NUM_REGS         = 16
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int AW      = C_S_AXI_ADDR_WIDTH;
  localparam int DW      = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W  = DW / 8;
  localparam int IDX_W   = $clog2(C_NUM_REGS);
  localparam int IDX_LSB = 2;
  localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
  localparam logic [AW-1:0] BASE_ADDR = AW'(C_BASEADDR);

  function automatic logic addr_hit(input logic [AW-1:0] addr);
    return addr[AW-1:IDX_MSB+1] == BASE_ADDR[AW-1:IDX_MSB+1];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] addr);
    return addr[IDX_MSB:IDX_LSB];
  endfunction

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Write channel state
  w_state_e          w_state_q, w_state_d;
  logic              awready_q, awready_d;
  logic              wready_q,  wready_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;
  logic              aw_got_q,  aw_got_d;
  logic              w_got_q,   w_got_d;
  logic [AW-1:0]     awaddr_q,  awaddr_d;
  logic [DW-1:0]     wdata_q,   wdata_d;
  logic [STRB_W-1:0] wstrb_q,   wstrb_d;

  // Read channel state
  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q,  rvalid_d;
  logic [DW-1:0]     rdata_q,   rdata_d;
  logic [1:0]        rresp_q,   rresp_d;

  logic              aw_hs, w_hs, ar_hs;
  logic              aw_have, w_have;
  logic [AW-1:0]     waddr_eff;
  logic [DW-1:0]     wdata_eff;
  logic [STRB_W-1:0] wstrb_eff;
  logic              w_hit, ar_hit;
  logic              mem_we;
  logic [DW-1:0]     mem_rdata;

  assign aw_hs   = S_AXI_AWVALID & awready_q;
  assign w_hs    = S_AXI_WVALID  & wready_q;
  assign ar_hs   = S_AXI_ARVALID & arready_q;
  assign aw_have = aw_got_q | aw_hs;
  assign w_have  = w_got_q  | w_hs;

  // A beat arriving this cycle takes precedence over the (empty) holding register.
  assign waddr_eff = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign wdata_eff = w_hs  ? S_AXI_WDATA  : wdata_q;
  assign wstrb_eff = w_hs  ? S_AXI_WSTRB  : wstrb_q;
  assign w_hit     = addr_hit(waddr_eff);
  assign ar_hit    = addr_hit(S_AXI_ARADDR);

  axi_lite_slave_regfile #(
    .NUM_REGS (C_NUM_REGS),
    .DATA_W   (DW),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk_i    (S_AXI_ACLK),
    .rst_i    (S_AXI_ARESET),
    .we_i     (mem_we),
    .widx_i   (addr_idx(waddr_eff)),
    .wdata_i  (wdata_eff),
    .wstrb_i  (wstrb_eff),
    .ridx_i   (addr_idx(S_AXI_ARADDR)),
    .rdata_o  (mem_rdata)
  );

  // NOTE: every variable gets its hold value first, so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_we    = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (aw_have && w_have) begin
          mem_we    = w_hit;
          bresp_d   = resp_for(w_hit);
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_RESP;
        end else begin
          // Readies also recover here on the first cycle after reset.
          awready_d = !aw_have;
          wready_d  = !w_have;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d   = ar_hit ? mem_rdata : '0;
          rresp_d   = resp_for(ar_hit);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: state registers use <= so every flop samples pre-edge values,
  // independent of process ordering.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: transaction-level model of the register window
// checked every cycle, plus directed transactions with literal expectations.
module tb_axi_lite_slave_mem;

  logic        clk = 1'b0;
  logic        S_AXI_ARESET = 1'b1;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  always #5 clk = ~clk;

  axi_lite_slave_mem dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (S_AXI_ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the window: 16 words at 0xC7000000, one outstanding B and one R.
  logic [31:0] mdl [16];
  bit          live = 1'b0, held = 1'b0;
  bit          b_pend = 1'b0, r_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
  logic [31:0] m_awaddr = '0, m_wdata = '0, exp_rdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [1:0]  exp_bresp = '0, exp_rresp = '0;
  int          b_rises = 0;
  bit          bvalid_prev = 1'b0;

  function automatic bit in_window(input logic [31:0] a);
    return (a >> 6) == (32'hC700_0000 >> 6);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  always @(posedge clk) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      live = 1'b1; held = 1'b1;
      b_pend = 1'b0; r_pend = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
    end else if (live) begin
      // Reads first: a read accepted with a write on the same edge sees old data.
      if (r_pend) begin
        if (S_AXI_RREADY) r_pend = 1'b0;
      end else if (!held && S_AXI_ARVALID) begin
        r_pend    = 1'b1;
        exp_rdata = in_window(S_AXI_ARADDR) ? mdl[word_of(S_AXI_ARADDR)] : 32'h0;
        exp_rresp = in_window(S_AXI_ARADDR) ? 2'b00 : 2'b10;
      end
      if (b_pend) begin
        if (S_AXI_BREADY) b_pend = 1'b0;
      end else if (!held) begin
        if (S_AXI_AWVALID && !aw_seen) begin aw_seen = 1'b1; m_awaddr = S_AXI_AWADDR; end
        if (S_AXI_WVALID && !w_seen) begin w_seen = 1'b1; m_wdata = S_AXI_WDATA; m_wstrb = S_AXI_WSTRB; end
        if (aw_seen && w_seen) begin
          if (in_window(m_awaddr)) begin
            for (int b = 0; b < 4; b++)
              if (m_wstrb[b]) mdl[word_of(m_awaddr)][8*b +: 8] = m_wdata[8*b +: 8];
          end
          exp_bresp = in_window(m_awaddr) ? 2'b00 : 2'b10;
          b_pend  = 1'b1;
          aw_seen = 1'b0;
          w_seen  = 1'b0;
        end
      end
      held = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      if (held) begin
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready",  S_AXI_WREADY,  0);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_bvalid",  S_AXI_BVALID,  0);
        check("rst_rvalid",  S_AXI_RVALID,  0);
        check("rst_bresp",   S_AXI_BRESP,   0);
        check("rst_rresp",   S_AXI_RRESP,   0);
        check("rst_rdata",   S_AXI_RDATA,   0);
      end else begin
        check("awready", S_AXI_AWREADY, !b_pend && !aw_seen);
        check("wready",  S_AXI_WREADY,  !b_pend && !w_seen);
        check("bvalid",  S_AXI_BVALID,  b_pend);
        if (b_pend) check("bresp", S_AXI_BRESP, exp_bresp);
        check("arready", S_AXI_ARREADY, !r_pend);
        check("rvalid",  S_AXI_RVALID,  r_pend);
        if (r_pend) begin
          check("rdata", S_AXI_RDATA, exp_rdata);
          check("rresp", S_AXI_RRESP, exp_rresp);
        end
      end
    end
    if (S_AXI_BVALID && !bvalid_prev) b_rises++;
    bvalid_prev = S_AXI_BVALID;
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_delay, output logic [1:0] resp);
    bit aw_done = 1'b0, w_done = 1'b0;
    int n = 0;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < w_lead; i++) begin
      @(negedge clk);
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      @(posedge clk); #1;
      if (w_done) S_AXI_WVALID = 1'b0;
    end
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      @(posedge clk); #1;
      if (aw_done) S_AXI_AWVALID = 1'b0;
      if (w_done) S_AXI_WVALID = 1'b0;
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("aw_w_accepted", aw_done && w_done, 1);
    n = 0;
    @(negedge clk);
    while (!S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    check("bvalid_seen", S_AXI_BVALID, 1);
    repeat (b_delay) @(negedge clk);
    resp = S_AXI_BRESP;
    #1 S_AXI_BREADY = 1'b1;
    @(posedge clk); #1 S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_delay,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done = 1'b0;
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (S_AXI_ARREADY) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_accepted", done, 1);
    n = 0;
    @(negedge clk);
    while (!S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
    check("rvalid_seen", S_AXI_RVALID, 1);
    repeat (r_delay) @(negedge clk);
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    #1 S_AXI_RREADY = 1'b1;
    @(posedge clk); #1 S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    int          rises0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata_literal", S_AXI_RDATA, 32'h0);
    S_AXI_ARESET = 1'b0;
    @(posedge clk); #1;
    check("awready_after_release", S_AXI_AWREADY, 1);
    check("arready_after_release", S_AXI_ARREADY, 1);

    // Full-word write then read back.
    axi_write(32'hC700_0004, 32'h1234_5678, 4'hF, 0, 0, br);
    check("w1_bresp", br, 2'b00);
    axi_read(32'hC700_0004, 0, rd, rr);
    check("r1_rdata", rd, 32'h1234_5678);
    check("r1_rresp", rr, 2'b00);

    // W leads AW by 3 cycles, low two bytes only.
    rises0 = b_rises;
    axi_write(32'hC700_0004, 32'hAAAA_5555, 4'b0011, 3, 0, br);
    check("w2_bresp", br, 2'b00);
    check("w2_one_bvalid_pulse", b_rises - rises0, 1);
    axi_read(32'hC700_0004, 0, rd, rr);
    check("r2_rdata", rd, 32'h1234_5555);

    // WSTRB=0 responds OKAY and writes nothing.
    axi_write(32'hC700_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, br);
    check("w3_bresp", br, 2'b00);
    axi_read(32'hC700_0010, 0, rd, rr);
    check("r3_rdata", rd, 32'h0);

    // Address bits [1:0] are ignored.
    axi_write(32'hC700_0007, 32'h9900_0000, 4'b1000, 0, 0, br);
    axi_read(32'hC700_0005, 0, rd, rr);
    check("r4_lowbits", rd, 32'h9934_5555);

    // Misses: write just above the window, read far away, then all words via model.
    axi_write(32'hC700_0040, 32'hBAD0_BAD0, 4'hF, 0, 0, br);
    check("w5_miss_bresp", br, 2'b10);
    axi_read(32'hC800_0000, 0, rd, rr);
    check("r5_miss_rdata", rd, 32'h0);
    check("r5_miss_rresp", rr, 2'b10);
    for (int i = 0; i < 16; i++) axi_read(32'hC700_0000 + 32'(4 * i), 0, rd, rr);
    axi_read(32'hC6FF_FFFC, 0, rd, rr);
    check("r6_below_base_rresp", rr, 2'b10);

    // Stalled BREADY / RREADY for 5 cycles.
    axi_write(32'hC700_000C, 32'hDEAD_BEEF, 4'hF, 0, 5, br);
    check("w7_stalled_bresp", br, 2'b00);
    axi_read(32'hC700_000C, 5, rd, rr);
    check("r7_stalled_rdata", rd, 32'hDEAD_BEEF);

    // Top word of the window, back-to-back reads.
    axi_write(32'hC700_003C, 32'hCAFE_F00D, 4'hF, 0, 0, br);
    axi_read(32'hC700_003C, 0, rd, rr);
    check("r8_last_word", rd, 32'hCAFE_F00D);
    axi_read(32'hC700_0000, 0, rd, rr);
    check("r8_word0", rd, 32'h0);

    // Same-edge read and write to word 2.
    axi_write(32'hC700_0008, 32'h0000_0001, 4'hF, 0, 0, br);
    fork
      axi_write(32'hC700_0008, 32'h0000_0002, 4'hF, 0, 0, br);
      axi_read(32'hC700_0008, 0, rd, rr);
    join
    check("r9_same_edge_old", rd, 32'h0000_0001);
    axi_read(32'hC700_0008, 0, rd, rr);
    check("r9_after_new", rd, 32'h0000_0002);

    // Reset while BVALID is pending.
    S_AXI_AWADDR = 32'hC700_0014; S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge clk);
    check("rst_bvalid_before", S_AXI_BVALID, 1);
    @(posedge clk); #1 S_AXI_ARESET = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_bvalid_cleared", S_AXI_BVALID, 0);
    @(posedge clk); #1 S_AXI_ARESET = 1'b0;
    S_AXI_BREADY = 1'b1;
    repeat (5) @(negedge clk);
    check("no_stray_bvalid", S_AXI_BVALID, 0);
    @(posedge clk); #1 S_AXI_BREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      axi_read(32'hC700_0000 + 32'(4 * i), 0, rd, rr);
      check("post_reset_word", rd, 32'h0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
